// File: rtl/lcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// lcd_seq_pkg
// Shared definitions for the HD44780-style LCD write sequencer:
//   - lcd_state_e     : sequencer FSM states
//   - DEF_T_*         : default timing constants (clock cycles at 50 MHz)
//   - INIT_CMD_TABLE  : power-on command list (function set, display on,
//                       clear, entry mode), entry 0 is issued first
//   - eff_cycles/max2 : helpers for delay-counter sizing and load values
// No ports (package).
// -----------------------------------------------------------------------------
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        INIT_LOAD = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        PULSE     = 3'd4,
        HOLD      = 3'd5,
        EXEC      = 3'd6
    } lcd_state_e;

    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_PULSE = 12;
    localparam int unsigned DEF_T_HOLD  = 2;
    localparam int unsigned DEF_T_EXEC  = 2000;
    localparam int unsigned DEF_T_LONG  = 82000;
    localparam int unsigned DEF_T_POWER = 750000;

    localparam int unsigned INIT_CMD_COUNT = 4;
    localparam logic [3:0][7:0] INIT_CMD_TABLE = {8'h06, 8'h01, 8'h0C, 8'h38};

    // A programmed delay of 0 still occupies one cycle in its state.
    function automatic int unsigned eff_cycles(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter shared by every timed state of the sequencer.
// Load N-1 to time N cycles; o_done is high while the count is zero and the
// counter parks there until the next load.
// Ports:
//   i_clk       in  clock (rising edge)
//   i_load      in  load i_load_val this cycle (has priority over counting)
//   i_load_val  in  WIDTH-bit value to load
//   o_done      out count has reached zero
// The parent drives a load while in reset, so no separate reset is needed.
// -----------------------------------------------------------------------------
module lcd_delay_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_write_sequencer
// Turns single-byte write requests into LCD bus cycles: RS/data setup,
// E strobe, hold, then an execution wait (long for clear/home commands).
// Optional macro LCD_INIT_SEQ_EN adds a power-on wait and a 4-command
// initialisation sequence before requests are accepted.
// Ports:
//   clk_clk       in   clock, all logic on rising edge
//   reset_reset   in   synchronous active-high reset
//   req_valid     in   requester presents a write
//   req_ready     out  write accepted this cycle when req_valid is high
//   req_rs        in   0 = command, 1 = character data
//   req_data      in   byte to write
//   busy          out  transfer or init in progress
//   init_done     out  display initialised, requests may be accepted
//   lcd_RS        out  register select
//   lcd_RW        out  read/write, tied to write
//   lcd_E         out  enable strobe
//   lcd_data_out  out  data bus drive value
//   lcd_data_oe   out  tri-state enable for the top-level data bus
// -----------------------------------------------------------------------------
module lcd_write_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_EXEC  = DEF_T_EXEC,
    parameter int unsigned T_LONG  = DEF_T_LONG,
    parameter int unsigned T_POWER = DEF_T_POWER
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_RS,
    output logic       lcd_RW,
    output logic       lcd_E,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe
);

    localparam int unsigned MAX_T = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC)),
                                         max2(T_LONG, T_POWER));
    localparam int unsigned CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(eff_cycles(T_SETUP) - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(eff_cycles(T_PULSE) - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(eff_cycles(T_HOLD)  - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(eff_cycles(T_EXEC)  - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(eff_cycles(T_LONG)  - 1);
`ifdef LCD_INIT_SEQ_EN
    localparam logic [CW-1:0] LD_POWER = CW'(eff_cycles(T_POWER) - 1);
`endif

    lcd_state_e      r_state;
    lcd_state_e      w_state_nxt;
    logic            w_load;
    logic [CW-1:0]   w_load_val;
    logic            w_done;
    logic            w_accept;
    logic            w_long;

    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_e;
    logic            r_ready;
    logic            r_busy;
    logic            r_init_done;
    logic            r_oe;
`ifdef LCD_INIT_SEQ_EN
    logic [1:0]      r_idx;
`endif

    lcd_delay_counter #(
        .WIDTH (CW)
    ) u_delay (
        .i_clk      (clk_clk),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait;
    // every init command uses it as well.
`ifdef LCD_INIT_SEQ_EN
    assign w_long = (!r_rs && (r_data[7:2] == '0)) || !r_init_done;
`else
    assign w_long = !r_rs && (r_data[7:2] == '0);
`endif

    // Reset is folded into the next-state logic so the counter is loaded
    // with the power-on wait on the same edge that selects PWR_WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_accept    = 1'b0;
        if (reset_reset) begin
            w_load = 1'b1;
`ifdef LCD_INIT_SEQ_EN
            w_state_nxt = PWR_WAIT;
            w_load_val  = LD_POWER;
`else
            w_state_nxt = IDLE;
`endif
        end else begin
            case (r_state)
`ifdef LCD_INIT_SEQ_EN
                PWR_WAIT: begin
                    if (w_done) begin
                        w_state_nxt = INIT_LOAD;
                    end
                end
                INIT_LOAD: begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                    w_load_val  = LD_SETUP;
                end
`endif
                IDLE: begin
                    if (req_valid && r_ready) begin
                        w_accept    = 1'b1;
                        w_state_nxt = SETUP;
                        w_load      = 1'b1;
                        w_load_val  = LD_SETUP;
                    end
                end
                SETUP: begin
                    if (w_done) begin
                        w_state_nxt = PULSE;
                        w_load      = 1'b1;
                        w_load_val  = LD_PULSE;
                    end
                end
                PULSE: begin
                    if (w_done) begin
                        w_state_nxt = HOLD;
                        w_load      = 1'b1;
                        w_load_val  = LD_HOLD;
                    end
                end
                HOLD: begin
                    if (w_done) begin
                        w_state_nxt = EXEC;
                        w_load      = 1'b1;
                        w_load_val  = w_long ? LD_LONG : LD_EXEC;
                    end
                end
                EXEC: begin
                    if (w_done) begin
`ifdef LCD_INIT_SEQ_EN
                        if (!r_init_done && (r_idx != 2'(INIT_CMD_COUNT - 1))) begin
                            w_state_nxt = INIT_LOAD;
                        end else begin
                            w_state_nxt = IDLE;
                        end
`else
                        w_state_nxt = IDLE;
`endif
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clk_clk) begin
        r_state <= w_state_nxt;
        if (reset_reset) begin
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_e         <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_oe        <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
            r_idx       <= '0;
`endif
        end else begin
            r_e         <= (w_state_nxt == PULSE);
            r_ready     <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_init_done <= r_init_done | (w_state_nxt == IDLE);
            r_oe        <= 1'b1;
            if (w_accept) begin
                r_rs   <= req_rs;
                r_data <= req_data;
            end
`ifdef LCD_INIT_SEQ_EN
            if (r_state == INIT_LOAD) begin
                r_rs   <= 1'b0;
                r_data <= INIT_CMD_TABLE[r_idx];
            end
            if ((r_state == EXEC) && (w_state_nxt == INIT_LOAD)) begin
                r_idx <= r_idx + 2'd1;
            end
`endif
        end
    end

    assign req_ready    = r_ready;
    assign busy         = r_busy;
    assign init_done    = r_init_done;
    assign lcd_RS       = r_rs;
    assign lcd_RW       = 1'b0;
    assign lcd_E        = r_e;
    assign lcd_data_out = r_data;
    assign lcd_data_oe  = r_oe;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
module tb_lcd_write_sequencer;

    localparam int unsigned S  = 2;
    localparam int unsigned P  = 3;
    localparam int unsigned H  = 1;
    localparam int unsigned X  = 10;
    localparam int unsigned L  = 40;
    localparam int unsigned PW = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic       init_done;
    logic       lcd_RS;
    logic       lcd_RW;
    logic       lcd_E;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    always #5 clk = ~clk;

    lcd_write_sequencer #(
        .T_SETUP (S),
        .T_PULSE (P),
        .T_HOLD  (H),
        .T_EXEC  (X),
        .T_LONG  (L),
        .T_POWER (PW)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs       (req_rs),
        .req_data     (req_data),
        .busy         (busy),
        .init_done    (init_done),
        .lcd_RS       (lcd_RS),
        .lcd_RW       (lcd_RW),
        .lcd_E        (lcd_E),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned gap;   // cycles from acceptance until req_ready returns
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one write occupies acceptance + setup + pulse + hold + execution.
    function automatic int unsigned model_gap(input logic rs, input logic [7:0] d);
        int unsigned ex;
        ex = (!rs && (d < 8'd4)) ? L : X;
        return 1 + S + P + H + ex;
    endfunction

    // Called at a negedge. Presents one write, waits for acceptance, then
    // watches the bus until req_ready returns.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d,
                            input int unsigned exp_gap);
        int unsigned k, e_first, e_cnt, e_runs, bus_bad, busy_bad, gap;
        logic prev_e;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        k = 0;
        while (req_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (req_ready !== 1'b1) begin
            check($sformatf("%s.accept_timeout", tag), 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e_first = 0; e_cnt = 0; e_runs = 0; bus_bad = 0; busy_bad = 0; gap = 0;
        prev_e = 1'b0;
        for (int unsigned c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (lcd_E === 1'b1) begin
                if (!prev_e) begin
                    e_runs++;
                    if (e_first == 0) e_first = c;
                end
                e_cnt++;
            end
            prev_e = (lcd_E === 1'b1);
            if (lcd_RS !== rs || lcd_data_out !== d) bus_bad++;
            if (req_ready === 1'b1) begin
                gap = c;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        check($sformatf("%s.e_start", tag), e_first, S + 1);
        check($sformatf("%s.e_width", tag), e_cnt, P);
        check($sformatf("%s.e_runs", tag), e_runs, 1);
        check($sformatf("%s.bus_stable", tag), bus_bad, 0);
        check($sformatf("%s.busy_high", tag), busy_bad, 0);
        check($sformatf("%s.ready_gap", tag), gap, exp_gap);
        check($sformatf("%s.busy_end", tag), {31'd0, busy}, 0);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned k;
        k = 0;
        while (req_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("%s.ready_wait", tag), {31'd0, req_ready}, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[7];
    int unsigned first_ready, second_ready, npulse, p2_start;
    logic [7:0]  pdata[2];
    logic        prev;
    int unsigned k;
    logic        r_rs_rand;
    logic [7:0]  r_d_rand;
`ifdef LCD_INIT_SEQ_EN
    int unsigned istart[4];
    logic [7:0]  idata[4];
    logic        irs[4];
    int unsigned iwid[4];
    int unsigned ni, done_n, busy_low;
`endif

    initial begin
        vecs[0] = '{rs: 1'b1, data: 8'h41, gap: 17};
        vecs[1] = '{rs: 1'b0, data: 8'h01, gap: 47};
        vecs[2] = '{rs: 1'b0, data: 8'h80, gap: 17};
        vecs[3] = '{rs: 1'b0, data: 8'h02, gap: 47};
        vecs[4] = '{rs: 1'b0, data: 8'h03, gap: 47};
        vecs[5] = '{rs: 1'b0, data: 8'h04, gap: 17};
        vecs[6] = '{rs: 1'b1, data: 8'h01, gap: 17};

        reset = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.E",     {31'd0, lcd_E}, 0);
        check("rst.RS",    {31'd0, lcd_RS}, 0);
        check("rst.RW",    {31'd0, lcd_RW}, 0);
        check("rst.data",  {24'd0, lcd_data_out}, 0);
        check("rst.oe",    {31'd0, lcd_data_oe}, 1);
        check("rst.ready", {31'd0, req_ready}, 0);
        check("rst.busy",  {31'd0, busy}, 0);
        reset = 1'b0;

`ifdef LCD_INIT_SEQ_EN
        ni = 0; done_n = 0; busy_low = 0; prev = 1'b0;
        for (int unsigned n = 2; n < 1000; n++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                done_n = n;
                break;
            end
            if (busy !== 1'b1 || req_ready !== 1'b0) busy_low++;
            if (lcd_E === 1'b1) begin
                if (!prev && ni < 4) begin
                    istart[ni] = n; idata[ni] = lcd_data_out; irs[ni] = lcd_RS; iwid[ni] = 0;
                    ni++;
                end
                if (ni > 0) iwid[ni-1]++;
            end
            prev = (lcd_E === 1'b1);
        end
        check("init.pulses", ni, 4);
        check("init.busy_until_done", busy_low, 0);
        if (ni == 4) begin
            check("init.power_wait", {31'd0, istart[0] >= PW + S + 1}, 1);
            check("init.cmd0", {24'd0, idata[0]}, 32'h38);
            check("init.cmd1", {24'd0, idata[1]}, 32'h0C);
            check("init.cmd2", {24'd0, idata[2]}, 32'h01);
            check("init.cmd3", {24'd0, idata[3]}, 32'h06);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("init.rs%0d", i), {31'd0, irs[i]}, 0);
                check($sformatf("init.width%0d", i), iwid[i], P);
            end
            for (int i = 0; i < 3; i++)
                check($sformatf("init.spacing%0d", i), istart[i+1] - istart[i], 1 + S + P + H + L);
            check("init.done_after_last", done_n - (istart[3] + P - 1), H + L + 1);
        end
        check("init.ready", {31'd0, req_ready}, 1);
`else
        @(negedge clk);
        check("post_rst.init_done", {31'd0, init_done}, 1);
        check("post_rst.ready",     {31'd0, req_ready}, 1);
`endif

        // Table-driven single writes
        for (int i = 0; i < 7; i++)
            do_write($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].gap);

        // Idle: bus holds the last written value
        repeat (5) @(negedge clk);
        check("idle.hold_RS",   {31'd0, lcd_RS}, 1);
        check("idle.hold_data", {24'd0, lcd_data_out}, 32'h01);

        // Back-to-back: valid held, second byte accepted in first IDLE cycle
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
        wait_ready("b2b");
        first_ready = 0; second_ready = 0; npulse = 0; p2_start = 0; prev = 1'b0;
        pdata[0] = 8'h00; pdata[1] = 8'h00;
        for (int unsigned c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) req_data = 8'h49;
            if (lcd_E === 1'b1 && !prev) begin
                if (npulse < 2) pdata[npulse] = lcd_data_out;
                if (npulse == 1) p2_start = c;
                npulse++;
            end
            prev = (lcd_E === 1'b1);
            if (req_ready === 1'b1) begin
                if (first_ready == 0) first_ready = c;
                else begin
                    second_ready = c;
                    break;
                end
            end
            if (first_ready != 0 && c == first_ready + 1) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b.first_ready",  first_ready, 1 + S + P + H + X);
        check("b2b.second_ready", second_ready, 2 * (1 + S + P + H + X));
        check("b2b.pulses",       npulse, 2);
        check("b2b.data0",        {24'd0, pdata[0]}, 32'h48);
        check("b2b.data1",        {24'd0, pdata[1]}, 32'h49);
        check("b2b.p2_start",     p2_start, (1 + S + P + H + X) + S + 1);

        // Reset during PULSE
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        wait_ready("rstmid");
        k = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (lcd_E !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid.reached_pulse", {31'd0, lcd_E}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid.E",     {31'd0, lcd_E}, 0);
        check("rstmid.ready", {31'd0, req_ready}, 0);
        check("rstmid.busy",  {31'd0, busy}, 0);
        check("rstmid.RS",    {31'd0, lcd_RS}, 0);
        check("rstmid.data",  {24'd0, lcd_data_out}, 0);
        reset = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        wait_ready("rstmid.reinit");
`else
        @(negedge clk);
        check("rstmid.ready_after", {31'd0, req_ready}, 1);
        k = 0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            if (lcd_E === 1'b1) k++;
        end
        check("rstmid.no_resume", k, 0);
`endif
        do_write("rstmid.fresh", 1'b1, 8'h33, model_gap(1'b1, 8'h33));

        // Randomized writes against the reference model
        for (int i = 0; i < 10; i++) begin
            r_rs_rand = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) r_d_rand = 8'($urandom_range(0, 7));
            else                           r_d_rand = 8'($urandom);
            do_write($sformatf("rnd%0d", i), r_rs_rand, r_d_rand, model_gap(r_rs_rand, r_d_rand));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_sequencer.md
LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

Interface
REQ-001 Parameter T_SETUP, default 2, clock cycles RS/data are stable before E rises.
REQ-002 Parameter T_PULSE, default 12, clock cycles E is high.
REQ-003 Parameter T_HOLD, default 2, clock cycles RS/data are held after E falls.
REQ-004 Parameter T_EXEC, default 2000, clock cycles of execution wait for a normal write (40 us at 50 MHz).
REQ-005 Parameter T_LONG, default 82000, clock cycles of execution wait for clear/home commands (1.64 ms).
REQ-006 Parameter T_POWER, default 750000, clock cycles of power-on wait (15 ms); used only with LCD_INIT_SEQ_EN.
REQ-007 clk_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset_reset  in  1  synchronous, active-high reset.
REQ-009 req_valid  in  1  requester presents a write.
REQ-010 req_ready  out  1  sequencer accepts a write this cycle.
REQ-011 req_rs  in  1  0 = command, 1 = character data.
REQ-012 req_data  in  8  byte to write.
REQ-013 busy  out  1  high from acceptance until execution wait ends.
REQ-014 init_done  out  1  display is initialised and ready for requests.
REQ-015 lcd_RS  out  1  LCD register select.
REQ-016 lcd_RW  out  1  LCD read/write; always 0.
REQ-017 lcd_E  out  1  LCD enable strobe.
REQ-018 lcd_data_out  out  8  LCD data bus drive value.
REQ-019 lcd_data_oe  out  1  tri-state enable for the top-level inout bus; always 1 after reset.

Function
REQ-020 FSM states: PWR_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-021 req_ready SHALL be high only in IDLE with init_done=1; a transfer occurs on req_valid && req_ready.
REQ-022 On acceptance, req_rs and req_data SHALL be registered, driven on lcd_RS and lcd_data_out from the next cycle, and the FSM SHALL enter SETUP.
REQ-023 SETUP lasts T_SETUP cycles, PULSE T_PULSE cycles (lcd_E=1 only here), HOLD T_HOLD cycles, then EXEC.
REQ-024 EXEC SHALL last T_LONG cycles when rs=0 and data[7:2]=0 (clear or home), else T_EXEC cycles, then return to IDLE.
REQ-025 lcd_E rises exactly T_SETUP+1 cycles after the acceptance cycle.
REQ-026 Back-to-back: req_ready reasserts in the first IDLE cycle, and a request held valid SHALL be accepted in that cycle with no bubble.
REQ-027 lcd_RS and lcd_data_out SHALL hold the last written value while in IDLE.
REQ-028 A request arriving while busy SHALL be ignored until req_ready is high; req_valid is not dropped by the sequencer.
REQ-029 Each delay counter SHALL be $clog2(max parameter)+1 bits wide, load N-1, and count down to 0; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-030 Reset SHALL give: lcd_E=0, lcd_RS=0, lcd_RW=0, lcd_data_out=0x00, lcd_data_oe=1, req_ready=0, busy=0.
REQ-031 Reset asserted mid-transfer SHALL drop lcd_E on the next edge and discard the transfer; no partial strobe resumes.
REQ-032 After reset, the FSM SHALL enter PWR_WAIT with the macro and IDLE without it.

Configuration
REQ-033 Macro LCD_INIT_SEQ_EN defined: after T_POWER cycles, the sequencer issues commands 0x38, 0x0C, 0x01, 0x06 (RS=0) through SETUP..EXEC, each with a T_LONG execution wait.
REQ-034 With LCD_INIT_SEQ_EN, init_done stays 0 and busy stays 1 until the last EXEC completes.
REQ-035 Without LCD_INIT_SEQ_EN, PWR_WAIT and INIT_LOAD are absent and init_done=1 from the first cycle after reset.

Structure
REQ-036 Package lcd_seq_pkg SHALL hold the state enum, the default timing constants, and the 4-entry init command table.
REQ-037 Sub-module lcd_delay_counter SHALL provide a loadable down-counter with a done flag, shared by all timed states.

Verification (bench parameters T_SETUP=2, T_PULSE=3, T_HOLD=1, T_EXEC=10, T_LONG=40, T_POWER=20)
REQ-038 Macro off, write RS=1 data=0x41 -> lcd_E high 3 cycles starting 3 cycles after acceptance; RS=1 and data=0x41 stable throughout; req_ready returns 2+3+1+10 cycles after E-start window begins.
REQ-039 Command 0x01 -> EXEC lasts 40 cycles; command 0x80 -> EXEC lasts 10 cycles.
REQ-040 req_valid held high with two queued bytes 0x48, 0x49 -> second accepted in the first IDLE cycle; exactly two E pulses.
REQ-041 Reset asserted during PULSE -> lcd_E=0, req_ready=0, busy=0 next cycle; fresh write afterwards completes normally.
REQ-042 Macro on -> after 20 idle cycles, four E pulses with data 0x38, 0x0C, 0x01, 0x06, each followed by 40-cycle EXEC; then init_done=1 and req_ready=1.
